// File: rtl/mem_read_arb_if.sv
// Bundle of requester, BRAM and response signals for mem_read_arb.
// slave = arbiter side, master = requesters plus memory side.
interface mem_read_arb_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_MAX_ADDRESS = 12,
  parameter int NUM_REQ         = 4
);
  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ*LOG_MAX_ADDRESS-1:0] req_addr;
  logic [NUM_REQ-1:0]                 grant;
  logic                               mem_read;
  logic [LOG_MAX_ADDRESS-1:0]         mem_addr;
  logic                               mem_valid;
  logic [DATA_WIDTH-1:0]              mem_data;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [DATA_WIDTH-1:0]              resp_data;
  logic                               err;

  modport slave (
    input  req, req_addr, mem_valid, mem_data,
    output grant, mem_read, mem_addr, resp_valid, resp_data, err
  );

  modport master (
    output req, req_addr, mem_valid, mem_data,
    input  grant, mem_read, mem_addr, resp_valid, resp_data, err
  );
endinterface

// File: rtl/mem_read_arb.sv
// Shared BRAM read-port arbiter: zero-latency grant, tag pipeline routes responses back.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module mem_read_arb #(
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_MAX_ADDRESS = 12,
  parameter int NUM_REQ         = 4,
  parameter int MEM_LATENCY     = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_read_arb_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  logic [ID_W-1:0]            ptr;
  logic                       gnt_any;
  logic [ID_W-1:0]            gnt_id;
  logic [NUM_REQ-1:0]         grant;
  logic [LOG_MAX_ADDRESS-1:0] mem_addr;

  logic [MEM_LATENCY-1:0]     vld_p;
  logic [ID_W-1:0]            id_p [MEM_LATENCY];
  logic                       last_vld;
  logic [ID_W-1:0]            last_id;

  logic [CNT_W-1:0]           settle;
  logic                       err_q;
  logic [NUM_REQ-1:0]         resp_valid;
  logic [DATA_WIDTH-1:0]      resp_data;

  // Requester index visited k places after the pointer, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // Arbitration: combinational search starting at ptr; descending scan so the
  // nearest requester after the pointer is the last (winning) assignment.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    grant    = '0;
    mem_addr = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[rr_index(ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_id  = rr_index(ptr, k);
      end
    end
    if (rst) gnt_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = gnt_any && (gnt_id == ID_W'(i));
      if (grant[i]) mem_addr = bus.req_addr[i*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
    end
  end

  // Fixed priority is the same search with the pointer pinned at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    end else begin
      ptr <= '0;
    end
`else
    end else if (gnt_any) begin
      ptr <= next_ptr(gnt_id);
    end
`endif
  end

  // Tag pipeline stage 0..MEM_LATENCY-1: valid is reset, ids are data only.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= gnt_any;
      for (int i = 1; i < MEM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    id_p[0] <= gnt_id;
    for (int i = 1; i < MEM_LATENCY; i++) id_p[i] <= id_p[i-1];
  end

  assign last_vld = vld_p[MEM_LATENCY-1];
  assign last_id  = id_p[MEM_LATENCY-1];

  // Response stage: memory data routed to the tag at the end of the pipeline.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (!rst && bus.mem_valid && last_vld) begin
      resp_valid[last_id] = 1'b1;
      resp_data           = bus.mem_data;
    end
  end

  // Reads issued before reset may still return during the settle window.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      settle <= CNT_W'(MEM_LATENCY);
    end else if (settle != '0) begin
      settle <= settle - 1'b1;
    end else if (bus.mem_valid != last_vld) begin
      err_q <= 1'b1;
    end
  end

  assign bus.grant      = grant;
  assign bus.mem_read   = gnt_any;
  assign bus.mem_addr   = mem_addr;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_mem_read_arb.sv
// Directed bench for mem_read_arb with a BRAM model and a per-cycle scoreboard.
module tb_mem_read_arb;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int NR = 4;
  localparam int ML = 1;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic             force_vld;
  logic             drop_vld;
  logic             bram_vld;
  logic [DW-1:0]    bram_data;
  logic [DW-1:0]    mem_arr [1 << AW];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_read_arb_if #(.DATA_WIDTH(DW), .LOG_MAX_ADDRESS(AW), .NUM_REQ(NR)) bus ();

  assign bus.req       = req;
  assign bus.req_addr  = req_addr;
  assign bus.mem_valid = (bram_vld & ~drop_vld) | force_vld;
  assign bus.mem_data  = bram_vld ? bram_data : 8'hEE;

  mem_read_arb #(.DATA_WIDTH(DW), .LOG_MAX_ADDRESS(AW), .NUM_REQ(NR), .MEM_LATENCY(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One-cycle BRAM
  always @(posedge clk) begin
    bram_vld  <= bus.mem_read;
    bram_data <= mem_arr[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // Scoreboard: outstanding reads kept as (due cycle, requester, expected data).
  int m_ptr = 0;
  bit m_err = 1'b0;
  int cyc = 0;
  int last_rst = 0;
  int due_q[$];
  int id_q[$];
  logic [DW-1:0] dat_q[$];

  always @(negedge clk) begin
    logic [NR-1:0] eg;
    logic [AW-1:0] ea;
    logic [NR-1:0] erv;
    logic [DW-1:0] erd;
    int gid;
    int idx;
    bit due;
    cyc++;
    eg = '0; ea = '0; erv = '0; erd = '0; gid = -1;
    if (!rst) begin
      for (int k = NR - 1; k >= 0; k--) begin
        idx = (m_ptr + k) % NR;
        if (req[idx]) gid = idx;
      end
    end
    if (gid >= 0) begin
      eg[gid] = 1'b1;
      ea = req_addr[gid*AW +: AW];
    end
    due = (due_q.size() > 0) && (due_q[0] == cyc);
    if (!rst && due && bus.mem_valid) begin
      erv[id_q[0]] = 1'b1;
      erd = dat_q[0];
    end
    chk("grant", bus.grant, eg);
    chk("mem_read", bus.mem_read, (eg != 0));
    chk("mem_addr", bus.mem_addr, ea);
    chk("resp_valid", bus.resp_valid, erv);
    chk("resp_data", bus.resp_data, erd);
    chk("err", bus.err, m_err);
    if (due) begin
      void'(due_q.pop_front());
      void'(id_q.pop_front());
      void'(dat_q.pop_front());
    end
    if (rst) begin
      due_q.delete(); id_q.delete(); dat_q.delete();
      m_ptr = 0; m_err = 1'b0; last_rst = cyc;
    end else begin
      if (cyc > last_rst + ML && (bus.mem_valid !== due)) m_err = 1'b1;
      if (gid >= 0) begin
        due_q.push_back(cyc + ML);
        id_q.push_back(gid);
        dat_q.push_back(mem_arr[ea]);
`ifndef MEM_ARB_FIXED_PRIO_EN
        m_ptr = (gid + 1) % NR;
`endif
      end
    end
  end

  initial begin
    logic [NR-1:0] rr_exp;
    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = 8'(i) ^ 8'h5A;
    mem_arr[32] = 8'hA5;
    mem_arr[33] = 8'h3C;
    rst = 1'b1; req = 4'b1111; req_addr = '0; force_vld = 1'b0; drop_vld = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_grant", bus.grant, 4'b0000);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 4'b0000);
    chk("rst_err", bus.err, 1'b0);
    tick(); rst = 1'b0; req = 4'b0000;
    @(negedge clk);
    chk("idle_grant", bus.grant, 4'b0000);

    // Single request
    tick(); req = 4'b0010; set_addr(1, 12'd32);
    @(negedge clk);
    chk("sr_grant", bus.grant, 4'b0010);
    chk("sr_mem_addr", bus.mem_addr, 12'd32);
    tick(); req = 4'b0000;
    @(negedge clk);
    chk("sr_resp_valid", bus.resp_valid, 4'b0010);
    chk("sr_resp_data", bus.resp_data, 8'hA5);

    // Back-to-back routing to two requesters
    tick(); req = 4'b0001; set_addr(0, 12'd32);
    @(negedge clk);
    chk("b2b_grant0", bus.grant, 4'b0001);
    tick(); req = 4'b0100; set_addr(2, 12'd33);
    @(negedge clk);
    chk("b2b_grant2", bus.grant, 4'b0100);
    chk("b2b_resp0", bus.resp_valid, 4'b0001);
    chk("b2b_data0", bus.resp_data, 8'hA5);
    tick(); req = 4'b0000;
    @(negedge clk);
    chk("b2b_resp2", bus.resp_valid, 4'b0100);
    chk("b2b_data2", bus.resp_data, 8'h3C);

    // Reset with a read in flight
    tick(); req = 4'b0100; set_addr(2, 12'd7);
    @(negedge clk);
    chk("mid_grant", bus.grant, 4'b0100);
    tick(); req = 4'b0000; rst = 1'b1;
    @(negedge clk);
    chk("mid_resp_in_rst", bus.resp_valid, 4'b0000);
    tick(); rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_no_resp", bus.resp_valid, 4'b0000);
      chk("mid_err", bus.err, 1'b0);
      tick();
    end

    // All four requesting for 8 cycles; ptr must start again at 0
    req = 4'b1111;
    for (int i = 0; i < NR; i++) set_addr(i, AW'(10 + i));
    for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      rr_exp = 4'b0001;
`else
      rr_exp = 4'(1 << (k % NR));
`endif
      @(negedge clk);
      chk("rr_grant", bus.grant, rr_exp);
      chk("rr_mem_read", bus.mem_read, 1'b1);
      tick();
    end
    req = 4'b0000;
    repeat (2) tick();

    // Stray mem_valid with nothing outstanding
    force_vld = 1'b1;
    @(negedge clk);
    chk("stray_resp", bus.resp_valid, 4'b0000);
    tick(); force_vld = 1'b0;
    @(negedge clk);
    chk("stray_err", bus.err, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("stray_err_sticky", bus.err, 1'b1);

    // Reset clears err; stray data right after reset is tolerated
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; force_vld = 1'b1;
    @(negedge clk);
    chk("settle_err0", bus.err, 1'b0);
    tick(); force_vld = 1'b0;
    @(negedge clk);
    chk("settle_err1", bus.err, 1'b0);

    // Outstanding read whose data never arrives
    tick(); req = 4'b0001; set_addr(0, 12'd3);
    tick(); req = 4'b0000; drop_vld = 1'b1;
    @(negedge clk);
    chk("drop_resp", bus.resp_valid, 4'b0000);
    tick(); drop_vld = 1'b0;
    @(negedge clk);
    chk("drop_err", bus.err, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_read_arb.md
MEM_READ_ARB -- requirements
Module: mem_read_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, BRAM word width.
REQ-002 SHALL have parameter LOG_MAX_ADDRESS, default 12, BRAM address width.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-004 SHALL have parameter MEM_LATENCY, default 1, cycles from BRAM read to valid_out (1..4).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req, input, NUM_REQ, per-requester read request, held until granted.
REQ-008 SHALL have port req_addr, input, NUM_REQ*LOG_MAX_ADDRESS, packed addresses; requester i at bits [i*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS].
REQ-009 SHALL have port grant, output, NUM_REQ, one-hot accept; req[i]&grant[i] = transfer this cycle.
REQ-010 SHALL have port mem_read, output, 1, BRAM read strobe.
REQ-011 SHALL have port mem_addr, output, LOG_MAX_ADDRESS, BRAM read address.
REQ-012 SHALL have port mem_valid, input, 1, BRAM read-data valid.
REQ-013 SHALL have port mem_data, input, DATA_WIDTH, BRAM read data.
REQ-014 SHALL have port resp_valid, output, NUM_REQ, one-hot response strobe per requester.
REQ-015 SHALL have port resp_data, output, DATA_WIDTH, response data, shared by all requesters.
REQ-016 SHALL have port err, output, 1, sticky protocol error flag.

Function
REQ-017 SHALL assert at most one grant bit per cycle, only for a requester with req high.
REQ-018 SHALL drive grant, mem_read, mem_addr combinationally from req, req_addr and registered state; zero latency from req to mem_read.
REQ-019 SHALL set mem_read = OR(grant) and mem_addr = address of granted requester; mem_addr = 0 when mem_read low.
REQ-020 SHALL arbitrate round-robin: search starts at pointer ptr; after grant to i, ptr <= (i+1) mod NUM_REQ; ptr unchanged when no grant.
REQ-021 SHALL keep a tag pipeline of MEM_LATENCY stages, each {valid, id[clog2(NUM_REQ)]}; stage 0 loads {mem_read, granted id} each cycle, stages shift every cycle.
REQ-022 SHALL, when mem_valid and last tag stage valid with id k, assert resp_valid[k] only and drive resp_data = mem_data in the same cycle.
REQ-023 SHALL drive resp_valid = 0 and resp_data = 0 when no routed response.
REQ-024 SHALL set err when mem_valid high and last tag stage invalid, or last tag stage valid and mem_valid low; err cleared only by rst; the stray response is dropped.
REQ-025 SHALL sustain one grant per cycle with continuous requests (full throughput), responses in grant order.
REQ-026 SHALL ignore req_addr of non-granted requesters; a requester holding req keeps competing each cycle.

Reset
REQ-027 SHALL, while rst high, force grant = 0, mem_read = 0, mem_addr = 0, resp_valid = 0, resp_data = 0.
REQ-028 SHALL on rst clear ptr to 0, all tag stages to invalid, err to 0.
REQ-029 SHALL on rst mid-operation discard all in-flight responses; SHALL NOT set err for mem_valid in the first MEM_LATENCY cycles after rst deasserts.

Configuration
REQ-030 SHALL, with macro MEM_ARB_FIXED_PRIO_EN defined, use fixed priority: lowest index with req high wins, ptr held at 0.
REQ-031 SHALL, without MEM_ARB_FIXED_PRIO_EN, use round-robin per REQ-020.

Verification
REQ-032 SHALL verify single request: reset, req=4'b0010, addr1=32, MEM preloaded mem[32]=0xA5 -> grant=4'b0010, mem_addr=32 same cycle; resp_valid=4'b0010, resp_data=0xA5 one cycle later.
REQ-033 SHALL verify round-robin: req=4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3, mem_read high all 8 cycles.
REQ-034 SHALL verify fixed priority with MEM_ARB_FIXED_PRIO_EN: req=4'b1111 held 4 cycles -> grant=4'b0001 every cycle.
REQ-035 SHALL verify back-to-back routing: req0 addr 32 then req2 addr 33 in consecutive cycles -> resp_valid 4'b0001 then 4'b0100 with mem[32], mem[33].
REQ-036 SHALL verify error: force mem_valid=1 with no outstanding read -> err=1 next cycle, resp_valid=0; err holds until rst.
REQ-037 SHALL verify reset mid-operation: rst during an outstanding read -> no resp_valid after rst, err stays 0, ptr restarts at 0.
